// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache between the fetch stage and main memory.
// Latency: a hit answers on the cycle after the request; a miss runs a line burst, then answers from the filled line.
// Backpressure: if_stall holds fetch for the whole miss; ICACHE_STATS_EN adds saturating hit/miss counters.
module instr_cache #(
  parameter int LINES          = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        flush,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic        if_stall,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OB = $clog2(WORDS_PER_LINE);   // word-offset bits
  localparam int IB = $clog2(LINES);            // index bits
  localparam int AB = IB + OB;                  // data array address bits
  localparam int TB = 16 - 1 - AB;              // tag bits
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      req_addr_q, req_addr_d;
  logic [OB-1:0]    cnt_q, cnt_d;
  logic             fill_flushed_q, fill_flushed_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic             if_valid_q, if_valid_d;
  logic [15:0]      if_instr_q, if_instr_d;
  logic             if_stall_q, if_stall_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic [15:0]      mem_addr_q, mem_addr_d;

  logic [15:0]   data_mem [LINES*WORDS_PER_LINE];
  logic [TB-1:0] tag_mem  [LINES];

  logic          dat_we;
  logic          tag_we;
  logic [AB-1:0] dat_waddr;

  // Lookup fields of the incoming PC and of the latched miss address
  logic [OB-1:0] a_off, r_off;
  logic [IB-1:0] a_idx, r_idx;
  logic [TB-1:0] a_tag, r_tag;
  assign a_off = if_addr[OB:1];
  assign a_idx = if_addr[AB:OB+1];
  assign a_tag = if_addr[15:AB+1];
  assign r_off = req_addr_q[OB:1];
  assign r_idx = req_addr_q[AB:OB+1];
  assign r_tag = req_addr_q[15:AB+1];

  // Byte-select bit of the PC carries no information for 16-bit words
  logic unused_addr_bits;
  assign unused_addr_bits = if_addr[0] ^ req_addr_q[0];

  // A hit needs both a valid line and a matching tag; flush in the same cycle forces a miss
  logic lookup_hit, take_hit, take_miss;
  assign lookup_hit = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
  assign take_hit   = (state_q == S_IDLE) && if_req && !flush && lookup_hit;
  assign take_miss  = (state_q == S_IDLE) && if_req && !take_hit;

  assign dat_waddr = {r_idx, cnt_q};

  // Next-state and next-output computation for the lookup / fill / respond sequence
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    cnt_d          = cnt_q;
    fill_flushed_d = fill_flushed_q;
    valid_d        = valid_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_stall_d     = if_stall_q;
    mem_rd_en_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    dat_we         = 1'b0;
    tag_we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if_valid_d = 1'b0;
        if (take_hit) begin
          if_valid_d = 1'b1;
          if_instr_d = data_mem[{a_idx, a_off}];
        end else if (take_miss) begin
          req_addr_d     = if_addr;
          mem_rd_en_d    = 1'b1;
          mem_addr_d     = {a_tag, a_idx, {(OB+1){1'b0}}};
          if_stall_d     = 1'b1;
          cnt_d          = '0;
          fill_flushed_d = 1'b0;
          state_d        = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_data_valid) begin
          dat_we = 1'b1;
          cnt_d  = cnt_q + OB'(1);
          if (cnt_q == LAST_WORD) begin
            state_d = S_RESP;
            // A flush seen during the burst leaves the line invalid
            if (!fill_flushed_q && !flush) begin
              tag_we         = 1'b1;
              valid_d[r_idx] = 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        if_valid_d = 1'b1;
        if_instr_d = data_mem[{r_idx, r_off}];
        if_stall_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
      if (state_q == S_FILL) fill_flushed_d = 1'b1;
    end
  end

  // Control state and registered outputs; a mid-burst reset simply abandons the fill
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      req_addr_q     <= '0;
      cnt_q          <= '0;
      fill_flushed_q <= 1'b0;
      valid_q        <= '0;
      if_valid_q     <= 1'b0;
      if_instr_q     <= '0;
      if_stall_q     <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      cnt_q          <= cnt_d;
      fill_flushed_q <= fill_flushed_d;
      valid_q        <= valid_d;
      if_valid_q     <= if_valid_d;
      if_instr_q     <= if_instr_d;
      if_stall_q     <= if_stall_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

  // Data and tag storage; contents need no reset because the valid bits gate every hit
  always_ff @(posedge clk) begin
    if (rst && dat_we) data_mem[dat_waddr] <= mem_data;
    if (rst && tag_we) tag_mem[r_idx]      <= r_tag;
  end

  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_stall  = if_stall_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters of accepted requests; only reset clears them
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (take_hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_d  = hit_cnt_q + 16'd1;
    if (take_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
